timer_irq: RTL and testbench
============================

Name: timer_irq

Overview:
Memory-mapped cycle timer that is the interrupt source feeding the TimerInterrupt input of coprocessor 0. It counts clock cycles and raises a level interrupt when the count reaches a software-programmed compare value. The line stays high until software writes the acknowledge address. It sits on the data-memory bus beside data memory; the core muxes rd_data into the load path when TimerAddress is high.

Parameters:
CYCLE_ADDR, 32'hffff001c, read: current cycle count; write: compare value
ACK_ADDR, 32'hffff006c, write: acknowledge (clear interrupt and overrun); read returns 0
CTRL_ADDR, 32'hffff0070, read/write: control/status
PERIOD_ADDR, 32'hffff0074, read/write: auto-reload period

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high; all state to reset values immediately
address  input  32  data-memory byte address from the core
data  input  32  store data
MemRead  input  1  load strobe for this cycle
MemWrite  input  1  store strobe for this cycle
rd_data  output  32  load data (combinational)
TimerAddress  output  1  address matches any of the four timer addresses (combinational)
TimerInterrupt  output  1  registered interrupt line to cp0

Behaviour:
- State: cycle_q[31:0], compare_q[31:0], period_q[31:0], enable_q, periodic_q, pending_q (drives TimerInterrupt), overrun_q.
- Reset values: cycle_q=0, compare_q=32'hffffffff, period_q=0, enable_q=1, periodic_q=0, pending_q=0, overrun_q=0. TimerInterrupt=0 while reset is high and after it.
- Counter: cycle_q increments by 1 each edge when enable_q=1. It holds when enable_q=0. It wraps 32'hffffffff->0 with no flag. Software cannot write it.
- match = enable_q & (cycle_q == compare_q), evaluated on the current registered values.
- Interrupt: pending_q is set at the edge where match=1. TimerInterrupt is therefore high starting the cycle after the matching count is present.
- Ack: MemWrite with address==ACK_ADDR clears pending_q and overrun_q at the edge. If match and ack occur on the same edge, set wins: pending_q=1 and overrun_q=0. No interrupt is ever lost.
- Overrun: match while pending_q=1 and no ack on that edge sets overrun_q. It is sticky until ack or reset.
- Compare write: MemWrite with address==CYCLE_ADDR loads compare_q<=data. If the same edge has a match, the match uses the old compare_q and the new value is loaded.
- Periodic mode: on a match edge with periodic_q=1, compare_q<=compare_q+period_q (mod 2^32). A software compare write on that same edge wins over the reload.
  - period_q=0 leaves compare unchanged, so the next match occurs after a 2^32-cycle wrap.
  - One-shot mode (periodic_q=0) leaves compare_q unchanged after a match.
- Control write at CTRL_ADDR: enable_q<=data[0], periodic_q<=data[1]. data[2] and higher bits are ignored; overrun_q is not writable. The write takes effect at the edge: the counter uses the new enable from the next cycle on.
- PERIOD_ADDR write loads period_q<=data.
- Reads: rd_data depends on MemRead and address (combinational, zero latency). Otherwise rd_data=0.
  - CYCLE_ADDR: cycle_q.
  - CTRL_ADDR: {29'b0, overrun_q, periodic_q, enable_q}.
  - PERIOD_ADDR: period_q.
  - ACK_ADDR: 0.
- TimerAddress = address equals any parameter address. It is independent of MemRead/MemWrite.
- MemRead and MemWrite both high: the write occurs at the edge, and the read returns pre-edge values.
- Writes to non-timer addresses have no effect.
- Reset mid-operation: an asserted interrupt drops asynchronously and the counter restarts from 0.

Test Plan:
- Reset, then sample: TimerInterrupt=0, CYCLE read increments 0,1,2,..., CTRL read=3'b001, PERIOD read=0.
- One-shot: write CYCLE_ADDR=20 when count=5. TimerInterrupt rises the cycle after count==20 and stays high 50 cycles. Write ACK_ADDR: it falls next cycle and never re-asserts before wrap.
- Periodic: PERIOD=10, CTRL=3, compare=100. Interrupts follow count 100, 110, 120. With no ack between 100 and 110, CTRL read shows overrun bit set (value 7). Ack clears it back to 3.
- Simultaneous: ack asserted on the exact edge of a match. TimerInterrupt remains 1 and overrun reads 0.
- Disable: CTRL=0 at count=40 and count holds at 41 for 30 cycles with no match. Then CTRL=1 resumes counting from 41.
- Async reset pulsed between edges while TimerInterrupt=1: the output drops immediately, the count reads 0 after release, and compare reads back as 32'hffffffff via a match test. No interrupt fires at count 20.

Source files
------------

// File: rtl/timer_irq.sv
// Memory-mapped cycle timer: counts cycles and raises a level interrupt to cp0
// when the count reaches a software compare value; held until acknowledged.
module timer_irq #(
  parameter logic [31:0] CYCLE_ADDR  = 32'hffff001c,
  parameter logic [31:0] ACK_ADDR    = 32'hffff006c,
  parameter logic [31:0] CTRL_ADDR   = 32'hffff0070,
  parameter logic [31:0] PERIOD_ADDR = 32'hffff0074
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] rd_data,
  output logic        TimerAddress,
  output logic        TimerInterrupt
);

  // Bus handshake: no valid/ready pair. MemWrite is a single-cycle store
  // strobe committed at the next rising edge; MemRead is a zero-latency load
  // strobe that only gates rd_data. Both may be high in one cycle, in which
  // case the read sees the values from before that edge.
  logic [31:0] cycle_q, compare_q, period_q;
  logic        enable_q, periodic_q, pending_q, overrun_q;

  logic sel_cycle, sel_ack, sel_ctrl, sel_period;
  logic cmp_wr, ack_wr, ctrl_wr, period_wr;
  logic match;

  assign sel_cycle  = (address == CYCLE_ADDR);
  assign sel_ack    = (address == ACK_ADDR);
  assign sel_ctrl   = (address == CTRL_ADDR);
  assign sel_period = (address == PERIOD_ADDR);

  assign cmp_wr    = MemWrite & sel_cycle;
  assign ack_wr    = MemWrite & sel_ack;
  assign ctrl_wr   = MemWrite & sel_ctrl;
  assign period_wr = MemWrite & sel_period;

  assign match = enable_q & (cycle_q == compare_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_q    <= 32'd0;
      compare_q  <= 32'hffffffff;
      period_q   <= 32'd0;
      enable_q   <= 1'b1;
      periodic_q <= 1'b0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (enable_q)
        cycle_q <= cycle_q + 32'd1;

      // A software compare write beats the periodic reload on the same edge.
      if (cmp_wr)
        compare_q <= data;
      else if (match && periodic_q)
        compare_q <= compare_q + period_q;

      if (period_wr)
        period_q <= data;

      if (ctrl_wr) begin
        enable_q   <= data[0];
        periodic_q <= data[1];
      end

      // Set beats ack so a match coinciding with an ack is never lost.
      if (match)
        pending_q <= 1'b1;
      else if (ack_wr)
        pending_q <= 1'b0;

      if (ack_wr)
        overrun_q <= 1'b0;
      else if (match && pending_q)
        overrun_q <= 1'b1;
    end
  end

  always_comb begin
    rd_data = 32'd0;
    if (MemRead) begin
      if (sel_cycle)
        rd_data = cycle_q;
      else if (sel_ctrl)
        rd_data = {29'd0, overrun_q, periodic_q, enable_q};
      else if (sel_period)
        rd_data = period_q;
    end
  end

  assign TimerAddress   = sel_cycle | sel_ack | sel_ctrl | sel_period;
  assign TimerInterrupt = pending_q;

endmodule

// File: tb/tb_timer_irq.sv
// Bench for timer_irq: register-map vector table plus multi-cycle sequences
// for one-shot, periodic, overrun, simultaneous ack, disable and async reset.
module tb_timer_irq;

  localparam logic [31:0] CYC  = 32'hffff001c;
  localparam logic [31:0] ACK  = 32'hffff006c;
  localparam logic [31:0] CTRL = 32'hffff0070;
  localparam logic [31:0] PER  = 32'hffff0074;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = 32'd0;
  logic [31:0] data = 32'd0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] rd_data;
  logic        TimerAddress;
  logic        TimerInterrupt;

  timer_irq dut (
    .clock(clock),
    .reset(reset),
    .address(address),
    .data(data),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .rd_data(rd_data),
    .TimerAddress(TimerAddress),
    .TimerInterrupt(TimerInterrupt)
  );

  // clock/reset block
  always #10 clock = ~clock;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  bit exp_en = 1'b1;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic [31:0] exp_rd;
    logic        exp_ta;
  } vec_t;

  vec_t vecs[8];

  // scoreboard
  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input string name, input logic [31:0] act);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: got %h, no expected value queued", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got %h expected %h (count %0d)", name, act, e, exp_cnt);
      end
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
    if (exp_en) exp_cnt++;
  endtask

  task automatic read_check(input string name, input logic [31:0] addr,
                            input logic [31:0] exp);
    address = addr;
    MemRead = 1'b1;
    push_exp(exp);
    #1;
    pop_check(name, rd_data);
    MemRead = 1'b0;
    address = 32'd0;
  endtask

  task automatic irq_check(input string name, input logic exp);
    push_exp({31'd0, exp});
    pop_check(name, {31'd0, TimerInterrupt});
  endtask

  task automatic tick_irq(input string name, input logic exp);
    push_exp({31'd0, exp});
    tick();
    pop_check(name, {31'd0, TimerInterrupt});
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] d);
    address  = addr;
    data     = d;
    MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
    address  = 32'd0;
    data     = 32'd0;
  endtask

  task automatic wait_cnt(input int n);
    int guard;
    guard = 0;
    while (exp_cnt < n && guard < 5000) begin
      tick();
      guard++;
    end
    if (exp_cnt != n) begin
      total++;
      bad++;
      $display("FAIL wait_cnt: reached %0d required %0d", exp_cnt, n);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    irq_check("irq_in_reset", 1'b0);
    repeat (2) @(posedge clock);
    #1;
    reset   = 1'b0;
    exp_cnt = 0;
    exp_en  = 1'b1;
  endtask

  initial begin
    #1_000_000;
    total++;
    bad++;
    $display("FAIL watchdog: time limit reached, got count %0d required end of test", exp_cnt);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    do_reset();
    irq_check("irq_after_reset", 1'b0);
    read_check("cycle_0", CYC, 32'd0);
    tick();
    read_check("cycle_1", CYC, 32'd1);
    tick();
    read_check("cycle_2", CYC, 32'd2);
    read_check("ctrl_reset", CTRL, 32'd1);
    read_check("period_reset", PER, 32'd0);

    bus_write(PER, 32'h12345678);
    bus_write(32'hffff0078, 32'd0);
    bus_write(32'h00000070, 32'd0);

    // register map table, all applied at count 5
    vecs[0] = '{CYC,          1'b1, 32'd5,         1'b1};
    vecs[1] = '{CTRL,         1'b1, 32'd1,         1'b1};
    vecs[2] = '{PER,          1'b1, 32'h12345678,  1'b1};
    vecs[3] = '{ACK,          1'b1, 32'd0,         1'b1};
    vecs[4] = '{CYC,          1'b0, 32'd0,         1'b1};
    vecs[5] = '{32'hffff0020, 1'b1, 32'd0,         1'b0};
    vecs[6] = '{32'hffff001d, 1'b1, 32'd0,         1'b0};
    vecs[7] = '{32'h00000000, 1'b1, 32'd0,         1'b0};
    for (int i = 0; i < 8; i++) begin
      address = vecs[i].addr;
      MemRead = vecs[i].rd;
      push_exp(vecs[i].exp_rd);
      push_exp({31'd0, vecs[i].exp_ta});
      #1;
      pop_check($sformatf("vec%0d_rd", i), rd_data);
      pop_check($sformatf("vec%0d_ta", i), {31'd0, TimerAddress});
    end
    MemRead = 1'b0;
    address = 32'd0;

    // one-shot: compare 20 written at count 5
    bus_write(CYC, 32'd20);
    wait_cnt(20);
    irq_check("oneshot_before", 1'b0);
    read_check("oneshot_cnt20", CYC, 32'd20);
    tick_irq("oneshot_rise", 1'b1);
    repeat (49) tick_irq("oneshot_hold", 1'b1);
    read_check("oneshot_no_overrun", CTRL, 32'd1);
    bus_write(ACK, 32'd0);
    irq_check("oneshot_ack", 1'b0);
    repeat (30) tick_irq("oneshot_quiet", 1'b0);

    // periodic: period 10, compare 100
    do_reset();
    bus_write(PER, 32'd10);
    bus_write(CTRL, 32'd3);
    bus_write(CYC, 32'd100);
    read_check("per_ctrl", CTRL, 32'd3);
    wait_cnt(100);
    irq_check("per_before100", 1'b0);
    tick_irq("per_at100", 1'b1);
    read_check("per_ctrl_101", CTRL, 32'd3);
    wait_cnt(110);
    irq_check("per_hold110", 1'b1);
    tick_irq("per_at110", 1'b1);
    read_check("per_overrun", CTRL, 32'd7);
    bus_write(ACK, 32'd0);
    irq_check("per_ack", 1'b0);
    read_check("per_overrun_clr", CTRL, 32'd3);
    wait_cnt(120);
    irq_check("per_before120", 1'b0);
    tick_irq("per_at120", 1'b1);
    wait_cnt(130);
    tick();
    read_check("per_overrun130", CTRL, 32'd7);

    // ack on the exact match edge (count 140)
    wait_cnt(140);
    bus_write(ACK, 32'd0);
    irq_check("simul_irq", 1'b1);
    read_check("simul_ctrl", CTRL, 32'd3);
    bus_write(ACK, 32'd0);
    irq_check("simul_ack2", 1'b0);

    // compare write on the match edge beats the reload
    wait_cnt(150);
    bus_write(CYC, 32'd200);
    irq_check("cmpwr_match", 1'b1);
    bus_write(ACK, 32'd0);
    irq_check("cmpwr_ack", 1'b0);
    wait_cnt(160);
    tick_irq("cmpwr_no160", 1'b0);
    wait_cnt(200);
    irq_check("cmpwr_before200", 1'b0);
    tick_irq("cmpwr_at200", 1'b1);

    // disable / resume, plus simultaneous read+write
    do_reset();
    bus_write(CYC, 32'd45);
    address  = PER;
    data     = 32'd7;
    MemRead  = 1'b1;
    MemWrite = 1'b1;
    push_exp(32'd0);
    #1;
    pop_check("rw_pre_edge", rd_data);
    tick();
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    address  = 32'd0;
    read_check("rw_post_edge", PER, 32'd7);
    wait_cnt(40);
    bus_write(CTRL, 32'd0);
    exp_en = 1'b0;
    repeat (30) tick_irq("dis_no_irq", 1'b0);
    read_check("dis_hold", CYC, 32'd41);
    read_check("dis_ctrl", CTRL, 32'd0);
    bus_write(CTRL, 32'hfffffffd);
    exp_en = 1'b1;
    read_check("en_ctrl_masked", CTRL, 32'd1);
    read_check("en_resume41", CYC, 32'd41);
    tick();
    read_check("en_count42", CYC, 32'd42);
    wait_cnt(45);
    irq_check("en_before45", 1'b0);
    tick_irq("en_at45", 1'b1);

    // async reset while the interrupt is high
    do_reset();
    bus_write(CYC, 32'd10);
    wait_cnt(10);
    tick_irq("ar_irq_high", 1'b1);
    #3;
    reset = 1'b1;
    #1;
    irq_check("ar_async_drop", 1'b0);
    @(posedge clock);
    #1;
    reset   = 1'b0;
    exp_cnt = 0;
    exp_en  = 1'b1;
    read_check("ar_cnt0", CYC, 32'd0);
    read_check("ar_ctrl", CTRL, 32'd1);
    wait_cnt(10);
    tick_irq("ar_no10", 1'b0);
    wait_cnt(20);
    tick_irq("ar_no20", 1'b0);
    repeat (4) tick_irq("ar_quiet", 1'b0);
    read_check("ar_cnt25", CYC, 32'd25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
